// File: rtl/fir_out_decim_fifo.sv
// fir_out_decim_fifo: decimates the fir sample stream by a programmable factor into a FWFT FIFO drained by valid/ready, with sticky overflow
module fir_out_decim_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic [7:0]    decim,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   fill,
  output logic          overflow,
  input  logic          clear_ovf
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [7:0] phase_q, phase_d, dec_q, dec_d, dec_eff;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0] fill_q, fill_d;
  logic ovf_q, ovf_d, keep, pop, wr, drop, wrap;
  logic [DW-1:0] mem_q [DEPTH];
  always_comb begin
    dec_eff = decim == 8'd0 ? 8'd1 : decim;
    wrap = phase_q == dec_q - 8'd1;
    keep = in_valid && phase_q == 8'd0;
    pop = out_valid && out_ready;
    wr = keep && (fill_q != FULL || pop);
    drop = keep && fill_q == FULL && !pop;
    phase_d = in_valid ? (wrap ? 8'd0 : phase_q + 8'd1) : phase_q;
    dec_d = in_valid && wrap ? dec_eff : dec_q;
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d = fill_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d = drop ? 1'b1 : clear_ovf ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      dec_q <= dec_eff;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dec_q <= dec_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q <= fill_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= in_data;
  end
  assign out_valid = fill_q != '0;
  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fill = fill_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// tb_fir_out_decim_fifo: directed self-checking bench for fir_out_decim_fifo
module tb_fir_out_decim_fifo;
  logic clk, rst_n, in_valid, out_ready, out_valid, overflow, clear_ovf;
  logic [31:0] in_data, out_data;
  logic [7:0] decim;
  logic [3:0] fill;
  int tests, fails;
  fir_out_decim_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .decim(decim), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fill(fill), .overflow(overflow), .clear_ovf(clear_ovf)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic [7:0] d);
    decim = d;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic drain(input string nm, input int first, input int step, input int n);
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'(first + i * step)) begin
        fails++;
        $display("FAIL %s[%0d] got valid=%0b data=%0d want data=%0d", nm, i, out_valid, out_data, first + i * step);
      end
      tick();
    end
    out_ready = 1'b0;
    tests++;
    if (fill !== 4'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_empty got fill=%0d valid=%0b want 0/0", nm, fill, out_valid);
    end
  endtask
  task automatic test_reset_passthrough;
    do_reset(8'd1);
    tests++;
    if (out_valid !== 1'b0 || fill !== 4'd0 || overflow !== 1'b0 || out_data !== 32'd0) begin
      fails++;
      $display("FAIL reset got valid=%0b fill=%0d ovf=%0b data=%0d want 0/0/0/0", out_valid, fill, overflow, out_data);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'(10 * i);
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'(10 * i) || fill !== 4'd1 || overflow !== 1'b0) begin
        fails++;
        $display("FAIL pass[%0d] got valid=%0b data=%0d fill=%0d ovf=%0b want 1/%0d/1/0", i, out_valid, out_data, fill, overflow, 10 * i);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || fill !== 4'd0) begin
      fails++;
      $display("FAIL pass_end got valid=%0b fill=%0d want 0/0", out_valid, fill);
    end
  endtask
  task automatic test_decim4;
    do_reset(8'd4);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (fill !== 4'd4) begin
      fails++;
      $display("FAIL dec4_fill got %0d want 4", fill);
    end
    drain("dec4", 0, 4, 4);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data = 32'(i);
      tick();
      in_valid = 1'b0;
      in_data = 32'hDEAD;
      tick();
    end
    tests++;
    if (fill !== 4'd4) begin
      fails++;
      $display("FAIL dec4gap_fill got %0d want 4", fill);
    end
    drain("dec4gap", 0, 4, 4);
  endtask
  task automatic test_factor_change;
    int exp_q[5] = '{0, 3, 5, 7, 9};
    do_reset(8'd3);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) decim = 8'd2;
      in_valid = 1'b1;
      in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (fill !== 4'd5) begin
      fails++;
      $display("FAIL chg_fill got %0d want 5", fill);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_data !== 32'(exp_q[i])) begin
        fails++;
        $display("FAIL chg[%0d] got %0d want %0d", i, out_data, exp_q[i]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask
  task automatic test_overflow;
    do_reset(8'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 32'(100 + i);
      tick();
      if (i == 7) begin
        tests++;
        if (fill !== 4'd8 || overflow !== 1'b0) begin
          fails++;
          $display("FAIL ovf_full got fill=%0d ovf=%0b want 8/0", fill, overflow);
        end
      end
      if (i == 8) begin
        tests++;
        if (fill !== 4'd8 || overflow !== 1'b1) begin
          fails++;
          $display("FAIL ovf_set got fill=%0d ovf=%0b want 8/1", fill, overflow);
        end
      end
    end
    drain("ovf_drain", 100, 1, 8);
  endtask
  task automatic test_full_push_pop;
    do_reset(8'd1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 32'(200 + i);
      tick();
    end
    out_ready = 1'b1;
    in_data = 32'd208;
    tick();
    tests++;
    if (fill !== 4'd8 || overflow !== 1'b0 || out_data !== 32'd201) begin
      fails++;
      $display("FAIL fullpp got fill=%0d ovf=%0b data=%0d want 8/0/201", fill, overflow, out_data);
    end
    out_ready = 1'b0;
    in_data = 32'd209;
    clear_ovf = 1'b1;
    tick();
    tests++;
    if (overflow !== 1'b1 || fill !== 4'd8) begin
      fails++;
      $display("FAIL setwins got ovf=%0b fill=%0d want 1/8", overflow, fill);
    end
    in_valid = 1'b0;
    tick();
    clear_ovf = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL clear got ovf=%0b want 0", overflow);
    end
    drain("fullpp_drain", 201, 1, 8);
  endtask
  task automatic test_async_reset;
    do_reset(8'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 32'(50 + i);
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (fill !== 4'd5) begin
      fails++;
      $display("FAIL ar_pre got fill=%0d want 5", fill);
    end
    decim = 8'd3;
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || fill !== 4'd0 || overflow !== 1'b0 || out_data !== 32'd0) begin
      fails++;
      $display("FAIL ar_now got valid=%0b fill=%0d ovf=%0b data=%0d want 0/0/0/0", out_valid, fill, overflow, out_data);
    end
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 32'd77;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd77 || fill !== 4'd1) begin
      fails++;
      $display("FAIL ar_first got valid=%0b data=%0d fill=%0d want 1/77/1", out_valid, out_data, fill);
    end
    in_data = 32'd78;
    tick();
    in_valid = 1'b0;
    tests++;
    if (fill !== 4'd1 || out_data !== 32'd77) begin
      fails++;
      $display("FAIL ar_second got fill=%0d data=%0d want 1/77", fill, out_data);
    end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    test_reset_passthrough();
    test_decim4();
    test_factor_change();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
